// File: rtl/button_events_pkg.sv
// Shared state encoding and helpers for button event decoding.
// The encodings match the other button-facing blocks of the Pong design.
package button_events_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_REL = 2'd0,
    ST_IDLE     = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_HELD     = 2'd3
  } state_e;

  // Button counts as down in both the pre-hold and the held phase.
  function automatic logic is_down(input state_e s);
    return (s == ST_PRESSED) || (s == ST_HELD);
  endfunction

endpackage

// File: rtl/button_events.sv
// Turns a debounced button level into registered one-cycle press, release,
// hold and auto-repeat pulses, plus a registered pressed level.
module button_events
  import button_events_pkg::*;
#(
  parameter int HOLD_CYCLES   = 12_500_000,
  parameter int REPEAT_CYCLES = 2_500_000,
  parameter int CNT_BITS      = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clean,
  output logic press,
  output logic release_p,
  output logic hold,
  output logic repeat_p,
  output logic pressed
);

  localparam logic [CNT_BITS-1:0] HOLD_LAST   = CNT_BITS'(HOLD_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] REPEAT_LAST = CNT_BITS'(REPEAT_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE     = CNT_BITS'(1);

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic                hold_q, hold_d;
  logic                repeat_q, repeat_d;
  logic                pressed_q, pressed_d;

  // Next-state, counter and pulse decode; release wins over any threshold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      ST_WAIT_REL: begin
        if (!clean) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_REL;
        end
      end
      ST_IDLE: begin
        if (clean) begin
          state_d = ST_PRESSED;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (!clean) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_HELD;
          hold_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!clean) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_WAIT_REL;
        cnt_d   = '0;
      end
    endcase
    pressed_d = is_down(state_d);
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT_REL;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      repeat_q  <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      repeat_q  <= repeat_d;
      pressed_q <= pressed_d;
    end
  end

  assign press     = press_q;
  assign release_p = release_q;
  assign hold      = hold_q;
  assign repeat_p  = repeat_q;
  assign pressed   = pressed_q;

endmodule
